// File: rtl/stack_pkg.sv
// Shared definitions for the memory-stage stack engine.
// Contents: request op encodings, FSM state enum, per-op word count and the
// layout of the pushed flag word ({13'b0, C, N, Z}).
package stack_pkg;

    typedef enum logic [1:0] {
        OpPushPc  = 2'b00,
        OpPopPc   = 2'b01,
        OpPushInt = 2'b10,
        OpPopRti  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        StIdle,
        StXfer,
        StDrain,
        StDone
    } state_e;

    // Zero bits above the 3 flag bits in the stacked flag word.
    localparam int unsigned FlagPadBits = 13;

    // Number of 16-bit stack words moved by an op.
    function automatic logic [1:0] op_words(logic [1:0] op);
        case (op)
            OpPushInt, OpPopRti: return 2'd3;
            default:             return 2'd2;
        endcase
    endfunction

    function automatic logic op_is_pop(logic [1:0] op);
        return (op == OpPopPc) || (op == OpPopRti);
    endfunction

    function automatic logic [15:0] flag_word(logic [2:0] flags);
        return {{FlagPadBits{1'b0}}, flags};
    endfunction

endpackage

// File: rtl/stack_control.sv
// Memory-stage stack engine: accepts one PC/flag push or pop request at a
// time, sequences the 16-bit data-memory accesses, keeps the stack pointer and
// returns popped PC/flags.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   req_valid/ready/op/pc/flags request handshake and payload
//   mem_addr/we/re/wdata        registered data-memory access (word address)
//   mem_rdata                   read data, valid the cycle after mem_re
//   rsp_valid/err/pc/flags      completion pulse and popped values
//   sp                          committed stack pointer (next free word)
module stack_control
    import stack_pkg::*;
#(
    parameter logic [31:0] SP_INIT  = 32'h0000_0FFF,
    parameter logic [31:0] SP_LIMIT = 32'h0000_0800
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [31:0] req_pc,
    input  logic [2:0]  req_flags,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic        mem_re,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    output logic        rsp_valid,
    output logic        rsp_err,
    output logic [31:0] rsp_pc,
    output logic [2:0]  rsp_flags,
    output logic [31:0] sp
);

    state_e      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] sp_q, sp_d;
    logic [1:0]  op_q, op_d;
    logic [31:0] pc_q, pc_d;
    logic [2:0]  flags_q, flags_d;
    logic        err_q, err_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic        mem_we_q, mem_we_d;
    logic        mem_re_q, mem_re_d;
    logic [15:0] mem_wdata_q, mem_wdata_d;
    logic [15:0] cap_hi_q, cap_hi_d;
    logic [15:0] cap_lo_q, cap_lo_d;
    logic [2:0]  cap_flags_q, cap_flags_d;
    logic [31:0] rsp_pc_q, rsp_pc_d;
    logic [2:0]  rsp_flags_q, rsp_flags_d;

    logic        accept;
    logic        bound_err;
    logic [1:0]  req_n;
    logic        issue;
    logic [1:0]  issue_idx;
    logic [1:0]  cap_idx;
    logic [1:0]  cap_slot;

    // Bound checks in 33 bits so neither side can wrap.
    always_comb begin
        req_n     = op_words(req_op);
        bound_err = op_is_pop(req_op)
            ? (({1'b0, sp_q} + {31'b0, req_n}) > {1'b0, SP_INIT})
            : (({1'b0, sp_q} + 33'd1) < ({1'b0, SP_LIMIT} + {31'b0, req_n}));
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            sp_q        <= SP_INIT;
            op_q        <= '0;
            pc_q        <= '0;
            flags_q     <= '0;
            err_q       <= 1'b0;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_re_q    <= 1'b0;
            mem_wdata_q <= '0;
            cap_hi_q    <= '0;
            cap_lo_q    <= '0;
            cap_flags_q <= '0;
            rsp_pc_q    <= '0;
            rsp_flags_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sp_q        <= sp_d;
            op_q        <= op_d;
            pc_q        <= pc_d;
            flags_q     <= flags_d;
            err_q       <= err_d;
            mem_addr_q  <= mem_addr_d;
            mem_we_q    <= mem_we_d;
            mem_re_q    <= mem_re_d;
            mem_wdata_q <= mem_wdata_d;
            cap_hi_q    <= cap_hi_d;
            cap_lo_q    <= cap_lo_d;
            cap_flags_q <= cap_flags_d;
            rsp_pc_q    <= rsp_pc_d;
            rsp_flags_q <= rsp_flags_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sp_d        = sp_q;
        op_d        = op_q;
        pc_d        = pc_q;
        flags_d     = flags_q;
        err_d       = err_q;
        cap_hi_d    = cap_hi_q;
        cap_lo_d    = cap_lo_q;
        cap_flags_d = cap_flags_q;
        rsp_pc_d    = rsp_pc_q;
        rsp_flags_d = rsp_flags_q;
        mem_addr_d  = '0;
        mem_we_d    = 1'b0;
        mem_re_d    = 1'b0;
        mem_wdata_d = '0;
        issue       = 1'b0;
        issue_idx   = '0;
        cap_idx     = '0;
        cap_slot    = '0;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    op_d        = req_op;
                    pc_d        = req_pc;
                    flags_d     = req_flags;
                    err_d       = bound_err;
                    rsp_pc_d    = '0;
                    rsp_flags_d = '0;
                    cnt_d       = '0;
                    if (bound_err) begin
                        state_d = StDone;
                    end else begin
                        state_d = StXfer;
                        issue   = 1'b1;
                    end
                end
            end
            StXfer: begin
                sp_d = op_is_pop(op_q) ? sp_q + 32'd1 : sp_q - 32'd1;
                if (cnt_q == op_words(op_q) - 2'd1) begin
                    state_d = op_is_pop(op_q) ? StDrain : StDone;
                end else begin
                    cnt_d     = cnt_q + 2'd1;
                    issue     = 1'b1;
                    issue_idx = cnt_d;
                end
            end
            StDrain: state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // Next access is launched from the post-update SP so the strobes are registered.
        if (issue) begin
            if (op_is_pop(op_d)) begin
                mem_re_d   = 1'b1;
                mem_addr_d = sp_d + 32'd1;
            end else begin
                mem_we_d   = 1'b1;
                mem_addr_d = sp_d;
                case (issue_idx)
                    2'd0:    mem_wdata_d = pc_d[31:16];
                    2'd1:    mem_wdata_d = pc_d[15:0];
                    default: mem_wdata_d = flag_word(flags_d);
                endcase
            end
        end

        // Capture the word read in the previous cycle. Slots: 0 flags, 1 PC lo,
        // 2 PC hi; POP_PC has no flag word so its indices start at slot 1.
        if (op_is_pop(op_q) &&
            (((state_q == StXfer) && (cnt_q != 2'd0)) || (state_q == StDrain))) begin
            cap_idx  = (state_q == StDrain) ? op_words(op_q) - 2'd1 : cnt_q - 2'd1;
            cap_slot = cap_idx + ((op_words(op_q) == 2'd2) ? 2'd1 : 2'd0);
            case (cap_slot)
                2'd0:    cap_flags_d = mem_rdata[2:0];
                2'd1:    cap_lo_d    = mem_rdata;
                default: cap_hi_d    = mem_rdata;
            endcase
        end

        // Last capture lands on the DRAIN -> DONE edge, so use the next values.
        if (state_q == StDrain) begin
            rsp_pc_d    = {cap_hi_d, cap_lo_d};
            rsp_flags_d = (op_q == OpPopRti) ? cap_flags_d : 3'b000;
        end
    end

    // Outputs
    always_comb begin
        req_ready = (state_q == StIdle) && !rst;
        accept    = req_valid && req_ready;
        rsp_valid = (state_q == StDone);
        rsp_err   = (state_q == StDone) && err_q;
        rsp_pc    = rsp_pc_q;
        rsp_flags = rsp_flags_q;
        sp        = sp_q;
        mem_addr  = mem_addr_q;
        mem_we    = mem_we_q;
        mem_re    = mem_re_q;
        mem_wdata = mem_wdata_q;
    end

endmodule
